// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit divide/remainder unit.
package div_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_ITERS = 32;

  localparam logic [DIV_XLEN-1:0] DIV_Q_DIV0  = 32'hFFFF_FFFF;
  localparam logic [DIV_XLEN-1:0] DIV_INT_MIN = 32'h8000_0000;

  // Encoding matches the RV32M funct3 low bits: bit0 = unsigned, bit1 = remainder.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP_A = 3'd1,
    S_PREP_B = 3'd2,
    S_ITER   = 3'd3,
    S_FIX    = 3'd4,
    S_DONE   = 3'd5
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/sub32.sv
// Plain 32-bit subtractor: rd = rs1 - rs2 (modulo 2^32).
module sub32 (
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] rd
);

  assign rd = rs1 - rs2;

endmodule

// File: rtl/div32_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit. One shared subtractor handles
// operand magnitude, 32 restoring-division steps and the final sign fix-up.
//
// Handshakes: a request transfers on a rising edge where start_valid and
// start_ready are both 1; a result transfers on a rising edge where
// res_valid and res_ready are both 1. rd/res_valid hold steady until then.
module div32_seq
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [1:0]          op,
  input  logic [DIV_XLEN-1:0] rs1,
  input  logic [DIV_XLEN-1:0] rs2,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DIV_XLEN-1:0] rd,
  output logic                busy
);

  div_state_e          state;
  div_op_e             op_q;
  logic [DIV_XLEN-1:0] a_q;      // dividend as accepted
  logic [DIV_XLEN-1:0] b_q;      // divisor as accepted
  logic [DIV_XLEN-1:0] q;        // |dividend| shifting out, quotient shifting in
  logic [DIV_XLEN-1:0] b_abs;
  // The partial remainder always ends a step below |divisor|, so its top bit
  // is 0 after every step; only the low 32 bits are kept.
  logic [DIV_XLEN-1:0] r_lo;
  logic [4:0]          cnt;
  logic                a_neg;
  logic                b_neg;

  logic [DIV_XLEN-1:0] sub_a;
  logic [DIV_XLEN-1:0] sub_b;
  logic [DIV_XLEN-1:0] sub_d;
  logic [DIV_XLEN:0]   r_sh;
  logic                take;
  logic                sgn;
  logic                is_rem;
  logic                div0;
  logic                ovf;
  logic [DIV_XLEN-1:0] special_val;
  logic [DIV_XLEN-1:0] fix_sel;
  logic                fix_neg;

  sub32 u_sub (
    .rs1 (sub_a),
    .rs2 (sub_b),
    .rd  (sub_d)
  );

  // Datapath decode and the state-selected subtractor operand mux.
  always_comb begin
    sgn         = op_is_signed(op_q);
    is_rem      = op_is_rem(op_q);
    r_sh        = {r_lo, q[DIV_XLEN-1]};
    take        = r_sh[DIV_XLEN] | (r_sh[DIV_XLEN-1:0] >= b_abs);
    div0        = (b_q == '0);
    ovf         = sgn && (a_q == DIV_INT_MIN) && (b_q == '1);
    special_val = div0 ? (is_rem ? a_q : DIV_Q_DIV0)
                       : (is_rem ? '0  : DIV_INT_MIN);
    fix_sel     = is_rem ? r_lo : q;
    fix_neg     = sgn && (is_rem ? a_neg : (a_neg ^ b_neg));
    sub_a       = '0;
    sub_b       = '0;
    case (state)
      S_PREP_A: sub_b = a_q;
      S_PREP_B: sub_b = b_q;
      S_ITER: begin
        sub_a = r_sh[DIV_XLEN-1:0];
        sub_b = b_abs;
      end
      S_FIX:    sub_b = fix_sel;
      default: begin
        sub_a = '0;
        sub_b = '0;
      end
    endcase
  end

  // Control FSM with the datapath registers and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_DIV;
      a_q       <= '0;
      b_q       <= '0;
      q         <= '0;
      b_abs     <= '0;
      r_lo      <= '0;
      cnt       <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      rd        <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            op_q  <= div_op_e'(op);
            a_q   <= rs1;
            b_q   <= rs2;
            state <= S_PREP_A;
          end
        end
        S_PREP_A: begin
          a_neg <= sgn & a_q[DIV_XLEN-1];
          q     <= (sgn & a_q[DIV_XLEN-1]) ? sub_d : a_q;
          state <= S_PREP_B;
        end
        S_PREP_B: begin
          if (div0 || ovf) begin
            rd        <= special_val;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            b_neg <= sgn & b_q[DIV_XLEN-1];
            b_abs <= (sgn & b_q[DIV_XLEN-1]) ? sub_d : b_q;
            r_lo  <= '0;
            cnt   <= '0;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          q    <= {q[DIV_XLEN-2:0], take};
          r_lo <= take ? sub_d : r_sh[DIV_XLEN-1:0];
          cnt  <= cnt + 5'd1;
          if (cnt == 5'(DIV_ITERS - 1)) state <= S_FIX;
        end
        S_FIX: begin
          rd        <= fix_neg ? sub_d : fix_sel;
          res_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign start_ready = (state == S_IDLE) && !rst;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed corner cases, backpressure,
// reset mid-operation and randomized operations against an arithmetic model.
module tb_div32_seq;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] rd;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  div32_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .rs1         (rs1),
    .rs2         (rs2),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .rd          (rd),
    .busy        (busy)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: RV32M semantics with plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return sa / sb;
      end
      2'b01: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      2'b10: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return sa % sb;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 2;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  // Issue a request and return once the DUT shows it accepted (called at a negedge).
  task automatic issue(input logic [1:0] op_i, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    while (!start_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("start_ready_wait", {31'd0, start_ready}, 32'd1);
    op          = op_i;
    rs1         = a;
    rs2         = b;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op          = 2'($urandom);
    rs1         = $urandom;
    rs2         = $urandom;
  endtask

  // Full operation: accept, latency and result checks, optional backpressure.
  task automatic run_op(input logic [1:0] op_i, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    logic [31:0] held;
    exp_q.push_back(ref_result(op_i, a, b));
    issue(op_i, a, b);
    lat = 0;
    @(negedge clk);
    while (!res_valid && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    check("res_valid", {31'd0, res_valid}, 32'd1);
    check("latency", 32'(lat), 32'(ref_latency(op_i, a, b)));
    check("rd", rd, exp_q.pop_front());
    held = rd;
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'($urandom_range(0, 1));
      rs1         = $urandom;
      rs2         = $urandom;
      op          = 2'($urandom);
      @(negedge clk);
      check("hold_rd", rd, held);
      check("hold_valid", {31'd0, res_valid}, 32'd1);
      check("hold_start_ready", {31'd0, start_ready}, 32'd0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("post_start_ready", {31'd0, start_ready}, 32'd1);
    check("post_res_valid", {31'd0, res_valid}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir_tbl[12] = '{
    '{2'b01, 32'd100,        32'd7},
    '{2'b11, 32'd100,        32'd7},
    '{2'b00, 32'hFFFF_FFF9,  32'd2},
    '{2'b10, 32'hFFFF_FFF9,  32'd2},
    '{2'b00, 32'd7,          32'hFFFF_FFFE},
    '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF},
    '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF},
    '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF},
    '{2'b01, 32'h0000_1234,  32'd0},
    '{2'b11, 32'h0000_1234,  32'd0},
    '{2'b00, 32'hFFFF_FFF0,  32'd0},
    '{2'b10, 32'hFFFF_FFF0,  32'd0}
  };

  // Main stimulus sequence
  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    rst         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    op          = 2'b00;
    rs1         = '0;
    rs2         = '0;

    repeat (2) @(negedge clk);
    check("reset_start_ready", {31'd0, start_ready}, 32'd0);
    check("reset_res_valid", {31'd0, res_valid}, 32'd0);
    check("reset_rd", rd, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("release_start_ready", {31'd0, start_ready}, 32'd1);

    for (int i = 0; i < 12; i++) run_op(dir_tbl[i].o, dir_tbl[i].a, dir_tbl[i].b, 0);

    // Backpressure with ignored requests while busy
    run_op(2'b00, 32'hFFFF_FF00, 32'd5, 10);
    run_op(2'b11, 32'd12345, 32'd0, 10);

    // Reset during ITER discards the operation
    issue(2'b01, 32'd999_999, 32'd13);
    repeat (10) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_start_ready", {31'd0, start_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_busy", {31'd0, busy}, 32'd0);
    check("after_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("after_rst_start_ready", {31'd0, start_ready}, 32'd1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd3, 0);
    check("divu_all_ones_by_3", ref_result(2'b01, 32'hFFFF_FFFF, 32'd3), 32'h5555_5555);

    // Randomized operations, with occasional corner operands
    for (int i = 0; i < 60; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: r_b = 32'($urandom_range(1, 16));
        3: r_b = -32'($urandom_range(1, 16));
        4: r_a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(r_op, r_a, r_b, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
